// File: rtl/ram8156_arbiter.sv
// Two-port req/ack arbiter and access sequencer for an 8156 static RAM.
// Latency: request sampled in IDLE, ack in the third cycle after, IDLE again on the fourth.
// Backpressure: a losing or busy-time request stays pending until the next IDLE; one access per 4 cycles.
// Optional build macro RAM_ARB_FIXED_PRIO_EN: port 0 always wins ties (no round-robin pointer).
module ram8156_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic [7:0] address,
  inout  wire  [7:0] data,
  output logic       CSn,
  output logic       RDn,
  output logic       WRn,
  output logic       IOMn
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state_q, state_d;
  logic       gnt_q, gnt_d;       // granted port of the access in flight
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       csn_q, csn_d;
  logic       rdn_q, rdn_d;
  logic       wrn_q, wrn_d;
  logic       iomn_q, iomn_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       drive_q, drive_d;   // arbiter owns the data bus (writes only)
  logic       pick;               // port chosen this IDLE cycle
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic       rr_q, rr_d;         // port that wins the next tie
`endif

  // Grant selection: only meaningful while in IDLE with a request pending.
  always_comb begin
`ifdef RAM_ARB_FIXED_PRIO_EN
    pick = ~req0;
`else
    pick = (req0 && req1) ? rr_q : req1;
`endif
  end

  // Next-state, latched request fields and registered strobe values.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = pick;
          we_d    = pick ? we1    : we0;
          addr_d  = pick ? addr1  : addr0;
          wdata_d = pick ? wdata1 : wdata0;
`ifndef RAM_ARB_FIXED_PRIO_EN
          rr_d    = ~pick;
`endif
          state_d = SETUP;
        end
      end
      SETUP:   state_d = STROBE;
      STROBE: begin
        // The RAM has driven the bus since the falling edge inside STROBE.
        if (!we_q) begin
          rdata_d = data;
        end
        state_d = HOLD;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so they come straight off flops.
    csn_d   = (state_d == IDLE);
    iomn_d  = (state_d == IDLE);
    rdn_d   = !((state_d == STROBE) && !we_d);
    wrn_d   = !((state_d == STROBE) && we_d);
    drive_d = (state_d != IDLE) && we_d;
    ack0_d  = (state_d == HOLD) && !gnt_d;
    ack1_d  = (state_d == HOLD) && gnt_d;
  end

  // State and output registers; reset abandons any access without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      csn_q   <= 1'b1;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      iomn_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      drive_q <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      csn_q   <= csn_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
      iomn_q  <= iomn_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      drive_q <= drive_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign data    = drive_q ? wdata_q : 8'hzz;
  assign address = addr_q;
  assign rdata   = rdata_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign CSn     = csn_q;
  assign RDn     = rdn_q;
  assign WRn     = wrn_q;
  assign IOMn    = iomn_q;

endmodule

// File: tb/tb_ram8156_arbiter.sv
// Scoreboard bench for ram8156_arbiter with a behavioural 8156 RAM on the bus.
// Stimulus pushes expected acks (port, cycle, rdata); a monitor pops on every ack.
// A probe drives 0x3C whenever CSn is high so a leaking arbiter driver is visible.
module tb_ram8156_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata, address;
  wire  [7:0] data;
  logic       CSn, RDn, WRn, IOMn;

  always #5 clk = ~clk;

  ram8156_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .address(address), .data(data),
    .CSn(CSn), .RDn(RDn), .WRn(WRn), .IOMn(IOMn)
  );

  // Cycle counter: during the cycle after posedge k the counter reads k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: reads on the falling edge of the RD strobe cycle; a write is captured
  // on the falling edge of the WR strobe cycle and committed only if chip select is
  // still asserted one cycle later, so an access abandoned by reset leaves memory alone.
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ram_dout  = 8'h00;
  logic       pend_vld  = 1'b0;
  logic [7:0] pend_addr = 8'h00;
  logic [7:0] pend_dat  = 8'h00;
  wire        ram_oe    = !CSn && !IOMn && !RDn;

  always @(negedge clk) begin
    if (pend_vld && !CSn) mem[pend_addr] <= pend_dat;
    pend_vld <= 1'b0;
    if (!CSn && !IOMn && !WRn) begin
      pend_vld  <= 1'b1;
      pend_addr <= address;
      pend_dat  <= data;
    end
    if (ram_oe) ram_dout <= mem[address];
  end

  assign data = ram_oe ? ram_dout : 8'hzz;
  assign data = CSn    ? 8'h3C    : 8'hzz;

  typedef struct {
    logic       port;
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   wrn_cnt = 0;
  logic [7:0] wr_dat = 8'h00;
  logic mon_en = 1'b0;
  logic done = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_exp(input logic port, input logic [7:0] rd, input int c);
    exp_t e;
    e.port  = port;
    e.rdata = rd;
    e.cyc   = c;
    sb_q.push_back(e);
  endfunction

  // One access from an idle block: the ack is expected three cycles after issue.
  task automatic access(input logic port, input logic we, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
    end
    push_exp(port, exp_rd, cyc + 3);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((port && ack1) || (!port && ack0)) begin
        seen = 1'b1;
        break;
      end
    end
    chk("ack_timeout", 32'(seen), 32'd1);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  initial begin
    int c0;
    int c;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    fork
      // Monitor: scoreboard on acks plus bus-ownership checks every cycle.
      forever begin
        @(negedge clk);
        if (mon_en) begin
          chk("ack_both", 32'(ack0 && ack1), 32'd0);
          if (ack0 || ack1) begin
            if (sb_q.size() == 0) begin
              chk("ack_unexpected", 32'(ack1), 32'hFFFF_FFFF);
            end else begin
              mon_e = sb_q.pop_front();
              chk("ack_port",  32'(ack1),  32'(mon_e.port));
              chk("ack_cycle", 32'(cyc),   32'(mon_e.cyc));
              chk("ack_rdata", 32'(rdata), 32'(mon_e.rdata));
            end
          end
          if (!RDn) begin
            chk("rd_wrn_high",   32'(WRn),  32'd1);
            chk("rd_contention", 32'(data), 32'(ram_dout));
          end
          if (CSn) chk("bus_idle", 32'(data), 32'h3C);
          if (!WRn) begin
            wrn_cnt++;
            wr_dat = data;
          end
        end
      end
      // Stimulus.
      begin
        repeat (2) @(negedge clk);
        chk("rst_csn",   32'(CSn),     32'd1);
        chk("rst_rdn",   32'(RDn),     32'd1);
        chk("rst_wrn",   32'(WRn),     32'd1);
        chk("rst_iomn",  32'(IOMn),    32'd1);
        chk("rst_addr",  32'(address), 32'h00);
        chk("rst_acks",  32'({ack0, ack1}), 32'd0);
        chk("rst_rdata", 32'(rdata),   32'h00);
        chk("rst_bus",   32'(data),    32'h3C);
        rst = 1'b0;
        mon_en = 1'b1;

        // Port 0 write 0x5A to 0x0B, then read it back.
        c0 = wrn_cnt;
        access(1'b0, 1'b1, 8'h0B, 8'h5A, 8'h00);
        chk("wr_pulse_len", 32'(wrn_cnt - c0), 32'd1);
        chk("wr_pulse_dat", 32'(wr_dat),       32'h5A);
        access(1'b0, 1'b0, 8'h0B, 8'h00, 8'h5A);

        // DMA fill from port 1, rdata must keep 0x5A; then port 0 reads back.
        for (int i = 0; i < 4; i++)
          access(1'b1, 1'b1, 8'(8'h20 + i), 8'(8'h10 + i), 8'h5A);
        for (int i = 0; i < 4; i++)
          access(1'b0, 1'b0, 8'(8'h20 + i), 8'h00, 8'(8'h10 + i));

        // Simultaneous reads after a reset: 0x0B holds 0x5A, 0x21 holds 0x11.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        c = cyc;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h0B;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h21;
`ifdef RAM_ARB_FIXED_PRIO_EN
        push_exp(1'b0, 8'h5A, c + 3);
        push_exp(1'b0, 8'h5A, c + 7);
        push_exp(1'b0, 8'h5A, c + 11);
        push_exp(1'b0, 8'h5A, c + 15);
`else
        push_exp(1'b0, 8'h5A, c + 3);
        push_exp(1'b1, 8'h11, c + 7);
        push_exp(1'b0, 8'h5A, c + 11);
        push_exp(1'b1, 8'h11, c + 15);
`endif
        repeat (15) @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during STROBE of a write to 0x40.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'hA5;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_strobe", 32'(WRn), 32'd0);
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        chk("abort_csn",  32'(CSn),  32'd1);
        chk("abort_wrn",  32'(WRn),  32'd1);
        chk("abort_rdn",  32'(RDn),  32'd1);
        chk("abort_iomn", 32'(IOMn), 32'd1);
        chk("abort_bus",  32'(data), 32'h3C);
        chk("abort_ack",  32'(ack0), 32'd0);
        rst = 1'b0;
        access(1'b0, 1'b0, 8'h40, 8'h00, 8'h00);
        repeat (4) @(negedge clk);
        done = 1'b1;
      end
      // Watchdog.
      begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete");
      end
    join_any
    disable fork;
    chk("run_complete",   32'(done),        32'd1);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
